// File: rtl/knight_pkg.sv
// Shared definitions for the knight's-tour replay path.
// Holds the command opcodes, default heading codes, response bytes, the
// sequencer state encoding and the one-hot move -> signed (dx, dy) decode
// used by the leg generator (and by solver-side models).
package knight_pkg;

  localparam logic [3:0] OP_MOVE    = 4'b0010;
  localparam logic [3:0] OP_FANFARE = 4'b0011;

  localparam logic [7:0] HDG_N_DEF = 8'h00;
  localparam logic [7:0] HDG_W_DEF = 8'h3F;
  localparam logic [7:0] HDG_S_DEF = 8'h7F;
  localparam logic [7:0] HDG_E_DEF = 8'hBF;

  localparam logic [7:0] RESP_FINAL = 8'hA5;
  localparam logic [7:0] RESP_STEP  = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_VERT,
    ST_VERT_W,
    ST_HORZ,
    ST_HORZ_W
  } seq_state_t;

  // Anything that is not exactly one-hot decodes to zero displacement.
  function automatic logic signed [2:0] move_dx(input logic [7:0] mv);
    case (mv)
      8'h01:   return -3'sd1;
      8'h02:   return  3'sd1;
      8'h04:   return -3'sd2;
      8'h08:   return -3'sd2;
      8'h10:   return -3'sd1;
      8'h20:   return  3'sd1;
      8'h40:   return  3'sd2;
      8'h80:   return  3'sd2;
      default: return  3'sd0;
    endcase
  endfunction

  function automatic logic signed [2:0] move_dy(input logic [7:0] mv);
    case (mv)
      8'h01:   return  3'sd2;
      8'h02:   return  3'sd2;
      8'h04:   return  3'sd1;
      8'h08:   return -3'sd1;
      8'h10:   return -3'sd2;
      8'h20:   return -3'sd2;
      8'h40:   return -3'sd1;
      8'h80:   return  3'sd1;
      default: return  3'sd0;
    endcase
  endfunction

  // Unsigned magnitude of a displacement, widened to the squares field.
  function automatic logic [3:0] leg_mag(input logic signed [2:0] d);
    logic [2:0] a;
    a = d[2] ? 3'(-d) : 3'(d);
    return {1'b0, a};
  endfunction

endpackage

// File: rtl/tour_cmd_seq_if.sv
// Command/response bus around the tour sequencer.
//   cmd_UART/cmd_rdy_UART/clr_cmd_rdy_UART : command from the UART wrapper
//   cmd/cmd_rdy/clr_cmd_rdy/cmd_done       : command to the command processor
//   resp_vld/resp                          : response byte back to the UART
// Modport master is the sequencer; slave is its environment.
interface tour_cmd_seq_if;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        cmd_done;
  logic        resp_vld;
  logic [7:0]  resp;

  modport master (
    input  cmd_UART, cmd_rdy_UART, clr_cmd_rdy, cmd_done,
    output clr_cmd_rdy_UART, cmd, cmd_rdy, resp_vld, resp
  );

  modport slave (
    output cmd_UART, cmd_rdy_UART, clr_cmd_rdy, cmd_done,
    input  clr_cmd_rdy_UART, cmd, cmd_rdy, resp_vld, resp
  );
endinterface

// File: rtl/tour_leg_gen.sv
// Combinational leg generator: turns a registered one-hot knight move into
// a vertical-leg command (plain move) and a horizontal-leg command (move
// with fanfare).
//   move_q   in  8  registered one-hot move
//   vert_cmd out 16 {OP_MOVE, N/S heading, |dy|}
//   horz_cmd out 16 {OP_FANFARE, E/W heading, |dx|}
// An illegal move yields zero squares with heading N on both legs.
module tour_leg_gen
  import knight_pkg::*;
#(
  parameter logic [7:0] HDG_N = HDG_N_DEF,
  parameter logic [7:0] HDG_W = HDG_W_DEF,
  parameter logic [7:0] HDG_S = HDG_S_DEF,
  parameter logic [7:0] HDG_E = HDG_E_DEF
) (
  input  logic [7:0]  move_q,
  output logic [15:0] vert_cmd,
  output logic [15:0] horz_cmd
);

  logic signed [2:0] dx;
  logic signed [2:0] dy;
  logic [7:0]        vert_hdg;
  logic [7:0]        horz_hdg;

  always_comb begin
    dx = move_dx(move_q);
    dy = move_dy(move_q);

    vert_hdg = dy[2] ? HDG_S : HDG_N;

    // Zero dx only happens for an illegal move; fall back to N there.
    if (dx == 3'sd0)
      horz_hdg = HDG_N;
    else if (dx[2])
      horz_hdg = HDG_W;
    else
      horz_hdg = HDG_E;

    vert_cmd = {OP_MOVE,    vert_hdg, leg_mag(dy)};
    horz_cmd = {OP_FANFARE, horz_hdg, leg_mag(dx)};
  end

endmodule

// File: rtl/tour_cmd_seq.sv
// Knight's-tour replay sequencer.
// In IDLE the UART command stream passes straight through to the command
// processor. On start_tour it walks the solver's moves by index, issuing a
// vertical then a horizontal leg command per move, each with a full
// rdy/clr/done handshake, and acks each completed move on resp.
//   clk, rst_n   clock, asynchronous active-low reset
//   start_tour   pulse: begin replay
//   mv_indx      index into the solver move readout
//   move         one-hot move at mv_indx
//   bus          tour_cmd_seq_if.master (UART in, command out, responses)
module tour_cmd_seq
  import knight_pkg::*;
#(
  parameter int         NUM_MOVES = 24,
  parameter logic [7:0] HDG_N     = HDG_N_DEF,
  parameter logic [7:0] HDG_W     = HDG_W_DEF,
  parameter logic [7:0] HDG_S     = HDG_S_DEF,
  parameter logic [7:0] HDG_E     = HDG_E_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_tour,
  output logic [4:0]    mv_indx,
  input  logic [7:0]    move,
  tour_cmd_seq_if.master bus
);

  localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);

  seq_state_t  state;
  seq_state_t  nxt_state;
  logic [4:0]  nxt_indx;
  logic        nxt_resp_vld;
  logic [7:0]  nxt_resp;
  logic        tour_sel;
  logic [7:0]  move_q;
  logic [7:0]  resp_q;
  logic        resp_vld_q;
  logic [15:0] vert_cmd;
  logic [15:0] horz_cmd;

  tour_leg_gen #(
    .HDG_N(HDG_N), .HDG_W(HDG_W), .HDG_S(HDG_S), .HDG_E(HDG_E)
  ) u_leg_gen (
    .move_q   (move_q),
    .vert_cmd (vert_cmd),
    .horz_cmd (horz_cmd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      mv_indx    <= '0;
      resp_vld_q <= 1'b0;
    end else begin
      state      <= nxt_state;
      mv_indx    <= nxt_indx;
      resp_vld_q <= nxt_resp_vld;
    end
  end

  // Data-only registers: the move is captured once per move so the leg
  // commands stay stable for the whole handshake.
  always_ff @(posedge clk) begin
    if (state == ST_LOAD)
      move_q <= move;
    resp_q <= nxt_resp;
  end

  always_comb begin
    nxt_state    = state;
    nxt_indx     = mv_indx;
    nxt_resp_vld = 1'b0;
    nxt_resp     = resp_q;
    tour_sel     = 1'b1;
    case (state)
      ST_IDLE: begin
        tour_sel = 1'b0;
        if (bus.cmd_done) begin
          nxt_resp_vld = 1'b1;
          nxt_resp     = RESP_FINAL;
        end
        if (start_tour) begin
          nxt_indx  = '0;
          nxt_state = ST_LOAD;
        end
      end
      ST_LOAD:   nxt_state = ST_VERT;
      ST_VERT:   if (bus.clr_cmd_rdy) nxt_state = ST_VERT_W;
      ST_VERT_W: if (bus.cmd_done)    nxt_state = ST_HORZ;
      ST_HORZ:   if (bus.clr_cmd_rdy) nxt_state = ST_HORZ_W;
      ST_HORZ_W: begin
        if (bus.cmd_done) begin
          nxt_resp_vld = 1'b1;
          if (mv_indx == LAST_INDX) begin
            nxt_resp  = RESP_FINAL;
            nxt_indx  = '0;
            nxt_state = ST_IDLE;
          end else begin
            nxt_resp  = RESP_STEP;
            nxt_indx  = mv_indx + 5'd1;
            nxt_state = ST_LOAD;
          end
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  // A start_tour in the same cycle as a pending UART command wins: the
  // UART command is neither offered nor consumed.
  assign bus.cmd = tour_sel ? ((state == ST_HORZ) ? horz_cmd : vert_cmd)
                            : bus.cmd_UART;
  assign bus.cmd_rdy = tour_sel ? ((state == ST_VERT) || (state == ST_HORZ))
                                : (bus.cmd_rdy_UART && !start_tour);
  assign bus.clr_cmd_rdy_UART = !tour_sel && bus.clr_cmd_rdy && !start_tour;
  assign bus.resp_vld = resp_vld_q;
  assign bus.resp     = resp_q;

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Bench for tour_cmd_seq: UART passthrough, move decode, reset mid-tour,
// full randomized tour with contention, against a table-driven model.
module tb_tour_cmd_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_tour;
  logic [4:0] mv_indx;
  logic [7:0] move;

  always #5 clk = ~clk;

  tour_cmd_seq_if bus ();

  tour_cmd_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_tour (start_tour),
    .mv_indx    (mv_indx),
    .move       (move),
    .bus        (bus)
  );

  // Solver model: combinational readout of the stored moves.
  logic [7:0] moves [24];
  assign move = (mv_indx < 5'd24) ? moves[mv_indx] : 8'h00;

  int checks   = 0;
  int failures = 0;

  logic [7:0] resp_log [$];
  int         uart_leak = 0;
  bit         in_tour   = 0;

  always @(negedge clk) begin
    if (bus.resp_vld) resp_log.push_back(bus.resp);
    if (in_tour && bus.clr_cmd_rdy_UART) uart_leak++;
  end

  // Knight move table, bit b -> (dx, dy).
  int dxt [8] = '{-1, 1, -2, -2, -1, 1, 2, 2};
  int dyt [8] = '{ 2, 2,  1, -1, -2, -2, -1, 1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_cmd(input logic [7:0] mv, input bit horz);
    int idx = -1;
    int d;
    logic [7:0] h;
    logic [7:0] one;
    for (int b = 0; b < 8; b++) begin
      one = 8'(1 << b);
      if (mv == one) idx = b;
    end
    if (idx < 0) return horz ? 16'h3000 : 16'h2000;
    d = horz ? dxt[idx] : dyt[idx];
    if (horz) h = (d > 0) ? 8'hBF : 8'h3F;
    else      h = (d > 0) ? 8'h00 : 8'h7F;
    return {(horz ? 4'h3 : 4'h2), h, 4'((d < 0) ? -d : d)};
  endfunction

  function automatic logic [7:0] resp_at(input int i);
    if (i < resp_log.size()) return resp_log[i];
    return 8'hxx;
  endfunction

  // Command processor model for one leg.
  task automatic serve_leg(input bit do_done, output logic [15:0] c, output bit ok);
    int n = 0;
    ok = 1;
    c  = '0;
    while (!bus.cmd_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_rdy) begin
      chk("rdy_timeout", 32'd0, 32'd1);
      ok = 0;
      return;
    end
    c = bus.cmd;
    repeat ($urandom_range(0, 20)) @(negedge clk);
    chk("cmd_stable", {16'h0, bus.cmd}, {16'h0, c});
    bus.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
    chk("rdy_drop", {31'h0, bus.cmd_rdy}, 32'd0);
    if (do_done) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      bus.cmd_done = 1'b1;
      @(negedge clk);
      bus.cmd_done = 1'b0;
    end
  endtask

  logic [15:0] lit [6] = '{16'h2002, 16'h33F1, 16'h27F1, 16'h3BF2, 16'h27F1, 16'h33F2};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] c;
    bit          ok;
    int          n_resp;

    rst_n            = 1'b0;
    start_tour       = 1'b0;
    bus.cmd_UART     = 16'h1234;
    bus.cmd_rdy_UART = 1'b0;
    bus.clr_cmd_rdy  = 1'b0;
    bus.cmd_done     = 1'b0;
    for (int i = 0; i < 24; i++) moves[i] = 8'(1 << $urandom_range(0, 7));

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mv_indx", {27'h0, mv_indx}, 32'd0);
    chk("rst_resp_vld", {31'h0, bus.resp_vld}, 32'd0);
    chk("rst_cmd", {16'h0, bus.cmd}, 32'h1234);
    chk("rst_rdy", {31'h0, bus.cmd_rdy}, 32'd0);
    bus.cmd_rdy_UART = 1'b1;
    #1;
    chk("rst_rdy_pass", {31'h0, bus.cmd_rdy}, 32'd1);
    bus.cmd_rdy_UART = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // UART passthrough
    @(negedge clk);
    bus.cmd_UART     = 16'h2003;
    bus.cmd_rdy_UART = 1'b1;
    #1;
    chk("pt_cmd", {16'h0, bus.cmd}, 32'h2003);
    chk("pt_rdy", {31'h0, bus.cmd_rdy}, 32'd1);
    chk("pt_clr_idle", {31'h0, bus.clr_cmd_rdy_UART}, 32'd0);
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b1;
    #1;
    chk("pt_clr", {31'h0, bus.clr_cmd_rdy_UART}, 32'd1);
    @(negedge clk);
    bus.clr_cmd_rdy  = 1'b0;
    bus.cmd_rdy_UART = 1'b0;
    resp_log.delete();
    repeat (3) @(negedge clk);
    bus.cmd_done = 1'b1;
    @(negedge clk);
    bus.cmd_done = 1'b0;
    @(negedge clk);
    #1;
    chk("pt_resp_n", resp_log.size(), 32'd1);
    chk("pt_resp", {24'h0, resp_at(0)}, 32'hA5);

    // Tour A: known decodes, then reset while waiting at index 10
    moves[0] = 8'h01;
    moves[1] = 8'h40;
    moves[2] = 8'h08;
    resp_log.delete();
    in_tour = 1;
    @(negedge clk);
    start_tour = 1'b1;
    @(negedge clk);
    start_tour = 1'b0;
    #1;
    chk("a_lat_load", {31'h0, bus.cmd_rdy}, 32'd0);
    @(negedge clk);
    #1;
    chk("a_lat_vert", {31'h0, bus.cmd_rdy}, 32'd1);
    for (int leg = 0; leg < 22; leg++) begin
      serve_leg(leg != 21, c, ok);
      if (!ok) break;
      if (leg < 6) chk($sformatf("a_lit%0d", leg), {16'h0, c}, {16'h0, lit[leg]});
      else chk($sformatf("a_leg%0d", leg), {16'h0, c},
               {16'h0, ref_cmd(moves[leg / 2], leg[0])});
      if (leg == 1) begin
        @(negedge clk);
        #1;
        chk("a_first_resp_n", resp_log.size(), 32'd1);
        chk("a_first_resp", {24'h0, resp_at(0)}, 32'h5A);
        chk("a_first_indx", {27'h0, mv_indx}, 32'd1);
      end
    end
    @(negedge clk);
    #1;
    chk("a_mid_indx", {27'h0, mv_indx}, 32'd10);
    chk("a_mid_resp_n", resp_log.size(), 32'd10);
    bus.cmd_UART     = 16'h2104;
    bus.cmd_rdy_UART = 1'b1;
    n_resp = resp_log.size();
    rst_n  = 1'b0;
    #1;
    chk("rst_mid_rdy", {31'h0, bus.cmd_rdy}, 32'd1);
    chk("rst_mid_cmd", {16'h0, bus.cmd}, 32'h2104);
    chk("rst_mid_indx", {27'h0, mv_indx}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n            = 1'b1;
    bus.cmd_rdy_UART = 1'b0;
    in_tour          = 0;
    @(negedge clk);
    #1;
    chk("rst_mid_noresp", resp_log.size(), n_resp);

    // Tour B: full replay with a pending UART command and stray inputs
    for (int i = 0; i < 24; i++)
      moves[i] = (i < 8) ? 8'(1 << i) : 8'(1 << $urandom_range(0, 7));
    resp_log.delete();
    uart_leak = 0;
    @(negedge clk);
    bus.cmd_UART     = 16'h4321;
    bus.cmd_rdy_UART = 1'b1;
    start_tour       = 1'b1;
    in_tour          = 1;
    @(negedge clk);
    start_tour = 1'b0;
    #1;
    chk("b_lat_load", {31'h0, bus.cmd_rdy}, 32'd0);
    @(negedge clk);
    #1;
    chk("b_lat_vert", {31'h0, bus.cmd_rdy}, 32'd1);
    for (int leg = 0; leg < 48; leg++) begin
      serve_leg(1'b1, c, ok);
      if (!ok) break;
      chk($sformatf("b_leg%0d", leg), {16'h0, c},
          {16'h0, ref_cmd(moves[leg / 2], leg[0])});
      if (leg == 9) begin
        start_tour = 1'b1;
        @(negedge clk);
        start_tour = 1'b0;
      end
      if (leg == 20) begin
        bus.cmd_done = 1'b1;
        @(negedge clk);
        bus.cmd_done = 1'b0;
      end
    end
    @(negedge clk);
    #1;
    chk("b_resp_n", resp_log.size(), 32'd24);
    for (int j = 0; j < 24; j++)
      chk($sformatf("b_resp%0d", j), {24'h0, resp_at(j)}, (j < 23) ? 32'h5A : 32'hA5);
    chk("b_end_indx", {27'h0, mv_indx}, 32'd0);
    chk("b_uart_leak", uart_leak, 32'd0);
    in_tour = 0;
    chk("b_pend_rdy", {31'h0, bus.cmd_rdy}, 32'd1);
    chk("b_pend_cmd", {16'h0, bus.cmd}, 32'h4321);
    bus.clr_cmd_rdy = 1'b1;
    #1;
    chk("b_pend_clr", {31'h0, bus.clr_cmd_rdy_UART}, 32'd1);
    @(negedge clk);
    bus.clr_cmd_rdy  = 1'b0;
    bus.cmd_rdy_UART = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
